// File: rtl/lut_k_frame_config_dffesr_srl.sv
// ---------------------------------------------------------------------------
// lut_k_frame_config_dffesr_srl
//
// K-input LUT BEL for the LUT4AB-style logic tile. The truth table comes from
// frame configuration bits, and the LUT can be followed by an optional output
// flop with enable and set/reset. The table can also run as a 2**K-deep
// serial-in shift register (SRL) that is read back through the LUT inputs.
// A majority-gate carry (Ci/Co) sits alongside for the carry chain.
//
// Configuration map, N = 2**LUT_SIZE:
//   [N-1:0] INIT table      [N]   FF (O from flop)   [N+1] IOmux (I0 = Ci)
//   [N+2]   SET_NORESET     [N+3] ASYNC_SR           [N+4] EN_IGNORE
//   [N+5]   SRL_MODE
//
// Ports
//   UserCLK     in   1             user clock, rising edge
//   UserRSTn    in   1             asynchronous active-low reset
//   I           in   LUT_SIZE      LUT inputs (I[0] replaceable by Ci)
//   Ci          in   1             carry in
//   Co          out  1             carry out, majority(Ci, I[1], I[2])
//   SR          in   1             output flop set/reset request, active-high
//   EN          in   1             clock enable for flop and SRL shift
//   D           in   1             SRL serial data in
//   O           out  1             LUT output or registered LUT output
//   SO          out  1             SRL serial out (table bit N-1)
//   ConfigBits  in   NoConfigBits  frame configuration
// ---------------------------------------------------------------------------
module lut_k_frame_config_dffesr_srl #(
   parameter int LUT_SIZE     = 4,
   parameter int NoConfigBits = 2**LUT_SIZE + 6
) (
   input  logic                    UserCLK,
   input  logic                    UserRSTn,
   input  logic [LUT_SIZE-1:0]     I,
   input  logic                    Ci,
   output logic                    Co,
   input  logic                    SR,
   input  logic                    EN,
   input  logic                    D,
   output logic                    O,
   output logic                    SO,
   input  logic [NoConfigBits-1:0] ConfigBits
);

   localparam int N = 2**LUT_SIZE;

   logic [N-1:0]        init_tbl;
   logic                cfg_ff;
   logic                cfg_iomux;
   logic                cfg_set;
   logic                cfg_async_sr;
   logic                cfg_en_ignore;
   logic                cfg_srl_mode;

   logic [N-1:0]        srl;
   logic [N-1:0]        tbl;
   logic [LUT_SIZE-1:0] lut_idx;
   logic                lut_out;
   logic                en_eff;
   logic                flop;
   logic                flop_force_n;

   assign init_tbl      = ConfigBits[N-1:0];
   assign cfg_ff        = ConfigBits[N];
   assign cfg_iomux     = ConfigBits[N+1];
   assign cfg_set       = ConfigBits[N+2];
   assign cfg_async_sr  = ConfigBits[N+3];
   assign cfg_en_ignore = ConfigBits[N+4];
   assign cfg_srl_mode  = ConfigBits[N+5];

   assign en_eff = EN | cfg_en_ignore;

   // ---- LUT read path -----------------------------------------------------
   assign lut_idx = {I[LUT_SIZE-1:1], (cfg_iomux ? Ci : I[0])};
   assign tbl     = cfg_srl_mode ? srl : init_tbl;
   assign lut_out = tbl[lut_idx];

   assign Co = (Ci & I[1]) | (Ci & I[2]) | (I[1] & I[2]);

   // ---- Output flop -------------------------------------------------------
   // Global reset and (when enabled) asynchronous SR share one async load
   // path, both forcing the flop to the SET_NORESET value. While the async
   // load is inactive with ASYNC_SR=1, SR is necessarily low, so the
   // synchronous SR term below only ever acts in synchronous SR mode.
   assign flop_force_n = UserRSTn & ~(cfg_async_sr & SR);

   always_ff @(posedge UserCLK or negedge flop_force_n) begin
      if (!flop_force_n) begin
         flop <= cfg_set;
      end else if (en_eff) begin
         flop <= SR ? cfg_set : lut_out;
      end
   end

   assign O = cfg_ff ? flop : lut_out;

   // ---- Shift-register table ----------------------------------------------
   // Outside SRL mode the register keeps reloading INIT so that entering SRL
   // mode starts from the configured table. SR deliberately has no effect.
   always_ff @(posedge UserCLK or negedge UserRSTn) begin
      if (!UserRSTn) begin
         srl <= init_tbl;
      end else if (!cfg_srl_mode) begin
         srl <= init_tbl;
      end else if (en_eff) begin
         srl <= {srl[N-2:0], D};
      end
   end

   assign SO = srl[N-1];

endmodule

// File: tb/tb_lut_k_frame_config_dffesr_srl.sv
module tb_lut_k_frame_config_dffesr_srl;

   localparam int K  = 4;
   localparam int N  = 16;
   localparam int CW = N + 6;

   logic          UserCLK = 1'b0;
   logic          UserRSTn = 1'b1;
   logic [K-1:0]  I = '0;
   logic          Ci = 1'b0;
   logic          SR = 1'b0;
   logic          EN = 1'b0;
   logic          D = 1'b0;
   logic [CW-1:0] ConfigBits = '0;
   logic          Co;
   logic          O;
   logic          SO;

   lut_k_frame_config_dffesr_srl #(
      .LUT_SIZE     (K),
      .NoConfigBits (CW)
   ) dut (
      .UserCLK    (UserCLK),
      .UserRSTn   (UserRSTn),
      .I          (I),
      .Ci         (Ci),
      .Co         (Co),
      .SR         (SR),
      .EN         (EN),
      .D          (D),
      .O          (O),
      .SO         (SO),
      .ConfigBits (ConfigBits)
   );

   always #5 UserCLK = ~UserCLK;

   typedef struct {
      logic        rst;
      logic [3:0]  i;
      logic        ci;
      logic        sr;
      logic        en;
      logic        d;
      logic [15:0] init;
      logic        ff;
      logic        iomux;
      logic        setv;
      logic        asr;
      logic        eni;
      logic        srlm;
   } stim_t;

   typedef struct {
      logic o;
      logic co;
      logic so;
      int   tag;
   } exp_t;

   exp_t  sbq[$];
   int    total = 0;
   int    bad   = 0;
   int    tag   = 0;

   stim_t cur;
   stim_t s;
   bit    m_srl[$];   // m_srl[0] is table bit 0, m_srl[15] is table bit N-1
   logic  m_flop;

   // ---- reference model --------------------------------------------------
   function automatic logic tbl_bit(input stim_t x, input int idx);
      if (x.srlm) return m_srl[idx];
      return x.init[idx];
   endfunction

   function automatic logic model_lut(input stim_t x);
      int idx;
      idx = (int'(x.i) / 2) * 2 + (x.iomux ? int'(x.ci) : int'(x.i[0]));
      return tbl_bit(x, idx);
   endfunction

   function automatic logic model_co(input stim_t x);
      return (int'(x.ci) + int'(x.i[1]) + int'(x.i[2])) >= 2;
   endfunction

   task automatic load_init(input logic [15:0] v);
      m_srl.delete();
      for (int b = 0; b < N; b++) m_srl.push_back(v[b]);
   endtask

   // effect of one rising edge, using the inputs held across that edge
   task automatic model_edge();
      logic lut;
      logic en_eff;
      if (!cur.rst) begin
         m_flop = cur.setv;
         load_init(cur.init);
      end else begin
         en_eff = cur.en | cur.eni;
         lut    = model_lut(cur);
         if (cur.asr && cur.sr) m_flop = cur.setv;
         else if (en_eff)       m_flop = cur.sr ? cur.setv : lut;
         if (!cur.srlm) begin
            load_init(cur.init);
         end else if (en_eff) begin
            void'(m_srl.pop_back());
            m_srl.push_front(cur.d);
         end
      end
   endtask

   task automatic model_async();
      if (!cur.rst) begin
         m_flop = cur.setv;
         load_init(cur.init);
      end else if (cur.asr && cur.sr) begin
         m_flop = cur.setv;
      end
   endtask

   task automatic apply(input stim_t nx);
      exp_t e;
      @(posedge UserCLK);
      #1;
      model_edge();
      cur = nx;
      {UserRSTn, SR, EN, D, Ci, I, ConfigBits} =
         {nx.rst, nx.sr, nx.en, nx.d, nx.ci, nx.i,
          nx.srlm, nx.eni, nx.asr, nx.setv, nx.iomux, nx.ff, nx.init};
      model_async();
      e.o   = nx.ff ? m_flop : model_lut(nx);
      e.co  = model_co(nx);
      e.so  = m_srl[N-1];
      e.tag = tag;
      tag++;
      sbq.push_back(e);
   endtask

   // ---- monitor ----------------------------------------------------------
   task automatic check(input string name, input logic act, input logic req, input int t);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s step=%0d got=%b want=%b", name, t, act, req);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge UserCLK);
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("O",  O,  e.o,  e.tag);
            check("Co", Co, e.co, e.tag);
            check("SO", SO, e.so, e.tag);
         end
      end
   end

   // ---- stimulus ---------------------------------------------------------
   initial begin : stimulus
      int waited;
      cur = '{default: '0};
      load_init(16'h0000);
      m_flop = 1'b0;

      // reset with SET_NORESET=1, then release and capture a 0
      s = '{default: '0};
      s.ff = 1'b1; s.setv = 1'b1;
      apply(s);
      apply(s);
      s.rst = 1'b1; s.en = 1'b1; s.i = 4'h0;
      apply(s);
      apply(s);

      // AND4, combinational output
      s.ff = 1'b0; s.setv = 1'b0; s.init = 16'h8000; s.i = 4'hF;
      apply(s);
      s.i = 4'hE;
      apply(s);

      // asynchronous vs synchronous SR
      s.ff = 1'b1; s.init = 16'hFFFF; s.i = 4'h0;
      apply(s);
      apply(s);
      s.asr = 1'b1;
      apply(s);
      s.sr = 1'b1;
      apply(s);
      apply(s);
      s.sr = 1'b0;
      apply(s);
      apply(s);
      s.asr = 1'b0;
      apply(s);
      s.sr = 1'b1; s.en = 1'b0;
      apply(s);
      apply(s);
      s.en = 1'b1;
      apply(s);
      apply(s);
      s.sr = 1'b0;

      // enable ignore
      s.eni = 1'b1; s.en = 1'b0;
      apply(s);
      apply(s);
      s.eni = 1'b0; s.init = 16'h0000;
      apply(s);
      apply(s);

      // SRL shifting and readback
      s.ff = 1'b0; s.en = 1'b1;
      apply(s);
      s.srlm = 1'b1;
      foreach (s.init[b]) begin end
      s.d = 1'b1; apply(s);
      s.d = 1'b0; apply(s);
      s.d = 1'b1; apply(s);
      s.d = 1'b1; apply(s);
      s.i = 4'd3; s.en = 1'b0; apply(s);
      s.i = 4'd2; apply(s);
      s.en = 1'b1; s.d = 1'b1;
      for (int c = 0; c < 17; c++) apply(s);
      s.en = 1'b0;
      apply(s);

      // IOmux and carry
      s.srlm = 1'b0; s.iomux = 1'b1; s.init = 16'h0002; s.i = 4'h0; s.ci = 1'b1;
      apply(s);
      apply(s);
      s.i = 4'b0010; s.ci = 1'b1;
      apply(s);
      s.ci = 1'b0;
      apply(s);

      // randomized traffic
      for (int c = 0; c < 800; c++) begin
         s.rst = ($urandom_range(0, 39) != 0);
         s.sr  = ($urandom_range(0, 5) == 0);
         s.en  = 1'($urandom_range(0, 1));
         s.d   = 1'($urandom_range(0, 1));
         s.ci  = 1'($urandom_range(0, 1));
         s.i   = 4'($urandom_range(0, 15));
         // configuration only changes while neither reset nor SR is active
         if (s.rst && !s.sr && ($urandom_range(0, 24) == 0)) begin
            s.init  = 16'($urandom());
            s.ff    = 1'($urandom_range(0, 1));
            s.iomux = 1'($urandom_range(0, 1));
            s.setv  = 1'($urandom_range(0, 1));
            s.asr   = 1'($urandom_range(0, 1));
            s.eni   = ($urandom_range(0, 3) == 0);
            s.srlm  = 1'($urandom_range(0, 1));
         end
         apply(s);
      end

      waited = 0;
      while (sbq.size() > 0 && waited < 20) begin
         @(posedge UserCLK);
         waited++;
      end
      if (sbq.size() > 0) begin
         bad++;
         $display("FAIL drain left=%0d want=0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
